mage_cfg_shadow_regs: RTL and testbench

Parametrised, double-buffered configuration register file for the Mage CGRA. The register bus writes a shadow bank (PE constants and per-PE config words). On a commit request, a row-by-row copy moves the shadow bank into the active bank that drives the processing element array (PEA), but only once the PEA reports idle. This lets software stage the next kernel's configuration while the current one runs. It sits between the register bus slave port and the PEA/stream configuration inputs.

---
 rtl/mage_cfg_pkg.sv | 50 +++++
 rtl/mage_cfg_addr_dec.sv | 52 +++++
 rtl/mage_cfg_shadow_regs.sv | 205 ++++++++++++++++++++
 tb/tb_mage_cfg_shadow_regs.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mage_cfg_pkg.sv
// mage_cfg_pkg: shared constants and types for the Mage CGRA configuration
// shadow register file.
//   - CTRL/STATUS word indices, CTRL bit positions, STATUS field positions
//   - cfg_state_e : commit FSM states
//   - cfg_region_e: decoded register region
//   - default word bases of the constant and config windows
//   - apply_wstrb : byte-enable merge helper
package mage_cfg_pkg;

  localparam int unsigned CTRL_W          = 0;
  localparam int unsigned STATUS_W        = 1;

  localparam int unsigned CTRL_COMMIT_BIT = 0;
  localparam int unsigned CTRL_ABORT_BIT  = 1;

  localparam int unsigned STAT_BUSY_BIT   = 0;
  localparam int unsigned STAT_WAIT_BIT   = 1;
  localparam int unsigned STAT_VALID_BIT  = 2;
  localparam int unsigned STAT_CNT_LSB    = 8;

  localparam int unsigned DEF_CONST_BASE_W = 64;
  localparam int unsigned DEF_CFG_BASE_W   = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_COPY,
    ST_DONE
  } cfg_state_e;

  typedef enum logic [2:0] {
    RG_CTRL,
    RG_STATUS,
    RG_CONST,
    RG_CFG,
    RG_UNMAPPED
  } cfg_region_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mage_cfg_addr_dec.sv
// mage_cfg_addr_dec: combinational word-address decode.
//   word_i   : word index (byte address with bits [1:0] dropped)
//   region_o : CTRL / STATUS / CONST / CFG / UNMAPPED
//   pe_o     : PE index within the constant or config window
//   k_o      : config word index within the PE (config window only)
module mage_cfg_addr_dec
  import mage_cfg_pkg::*;
#(
  parameter int unsigned AW            = 12,
  parameter int unsigned N             = 4,
  parameter int unsigned M             = 4,
  parameter int unsigned N_CFG_REGS_PE = 2,
  parameter int unsigned CONST_BASE_W  = DEF_CONST_BASE_W,
  parameter int unsigned CFG_BASE_W    = DEF_CFG_BASE_W,
  parameter int unsigned PEW           = (N*M > 1) ? $clog2(N*M) : 1,
  parameter int unsigned KW            = (N_CFG_REGS_PE > 1) ? $clog2(N_CFG_REGS_PE) : 1
) (
  input  logic [AW-3:0]  word_i,
  output cfg_region_e    region_o,
  output logic [PEW-1:0] pe_o,
  output logic [KW-1:0]  k_o
);

  localparam int unsigned NPE = N * M;

  logic [31:0] w;
  logic [31:0] off_const;
  logic [31:0] off_cfg;

  assign w = 32'(word_i);

  always_comb begin
    region_o  = RG_UNMAPPED;
    pe_o      = '0;
    k_o       = '0;
    off_const = w - 32'(CONST_BASE_W);
    off_cfg   = w - 32'(CFG_BASE_W);
    if (w == 32'(CTRL_W)) begin
      region_o = RG_CTRL;
    end else if (w == 32'(STATUS_W)) begin
      region_o = RG_STATUS;
    end else if (w >= 32'(CONST_BASE_W) && off_const < 32'(NPE)) begin
      region_o = RG_CONST;
      pe_o     = PEW'(off_const);
    end else if (w >= 32'(CFG_BASE_W) && off_cfg < 32'(NPE * N_CFG_REGS_PE)) begin
      region_o = RG_CFG;
      pe_o     = PEW'(off_cfg / 32'(N_CFG_REGS_PE));
      k_o      = KW'(off_cfg % 32'(N_CFG_REGS_PE));
    end
  end

endmodule

// File: rtl/mage_cfg_shadow_regs.sv
// mage_cfg_shadow_regs: double-buffered PE configuration register file.
// The register bus writes the shadow bank; a commit copies it row by row into
// the active bank once the PEA reports idle.
//   clk_i, rst_n_i      : clock, asynchronous active-low reset
//   reg_*               : register bus slave (combinational response)
//   pea_idle_i          : PEA has no in-flight work
//   active_constants_o  : active constants, PE pe at [pe*32 +: 32], pe = r*M+c
//   active_cfg_o        : active config words, [(pe*N_CFG_REGS_PE+k)*32 +: 32]
//   cfg_valid_o         : at least one commit has completed
//   commit_done_o       : one-cycle pulse in the DONE state
module mage_cfg_shadow_regs
  import mage_cfg_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned M             = 4,
  parameter int unsigned N_CFG_REGS_PE = 2,
  parameter int unsigned AW            = 12,
  parameter int unsigned CONST_BASE_W  = DEF_CONST_BASE_W,
  parameter int unsigned CFG_BASE_W    = DEF_CFG_BASE_W
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            reg_valid_i,
  input  logic                            reg_write_i,
  input  logic [AW-1:0]                   reg_addr_i,
  input  logic [31:0]                     reg_wdata_i,
  input  logic [3:0]                      reg_wstrb_i,
  output logic                            reg_ready_o,
  output logic [31:0]                     reg_rdata_o,
  output logic                            reg_error_o,
  input  logic                            pea_idle_i,
  output logic [N*M*32-1:0]               active_constants_o,
  output logic [N*M*N_CFG_REGS_PE*32-1:0] active_cfg_o,
  output logic                            cfg_valid_o,
  output logic                            commit_done_o
);

  localparam int unsigned NPE = N * M;
  localparam int unsigned NK  = N_CFG_REGS_PE;
  localparam int unsigned PEW = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int unsigned KW  = (NK > 1) ? $clog2(NK) : 1;

  logic [31:0] sh_const_q  [NPE];
  logic [31:0] sh_cfg_q    [NPE][NK];
  logic [31:0] act_const_q [NPE];
  logic [31:0] act_cfg_q   [NPE][NK];

  cfg_state_e  state_q;
  logic [2:0]  row_q;
  logic        cfg_valid_q;
  logic        done_q;
  logic [7:0]  cnt_q;

  cfg_region_e    region;
  logic [PEW-1:0] pe_idx;
  logic [KW-1:0]  k_idx;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^reg_addr_i[1:0];

  mage_cfg_addr_dec #(
    .AW            (AW),
    .N             (N),
    .M             (M),
    .N_CFG_REGS_PE (NK),
    .CONST_BASE_W  (CONST_BASE_W),
    .CFG_BASE_W    (CFG_BASE_W),
    .PEW           (PEW),
    .KW            (KW)
  ) u_dec (
    .word_i   (reg_addr_i[AW-1:2]),
    .region_o (region),
    .pe_o     (pe_idx),
    .k_o      (k_idx)
  );

  logic is_wr, ctrl_commit, ctrl_abort, abort_only, stall;
  logic wr_acc, commit_acc, abort_acc;

  assign is_wr       = reg_valid_i & reg_write_i;
  assign ctrl_commit = reg_wdata_i[CTRL_COMMIT_BIT] & reg_wstrb_i[0];
  assign ctrl_abort  = reg_wdata_i[CTRL_ABORT_BIT] & reg_wstrb_i[0];
  assign abort_only  = ctrl_abort & ~ctrl_commit;

  // Shadow/CTRL writes stall while a commit is pending or copying; an
  // abort-only CTRL write must still get through while waiting for idle.
  always_comb begin
    stall = 1'b0;
    if (is_wr && (region == RG_CTRL || region == RG_CONST || region == RG_CFG)) begin
      if (state_q == ST_COPY) begin
        stall = 1'b1;
      end else if (state_q == ST_WAIT_IDLE) begin
        stall = !(region == RG_CTRL && abort_only);
      end
    end
  end

  assign reg_ready_o = ~stall;
  assign reg_error_o = reg_valid_i & (region == RG_UNMAPPED);
  assign wr_acc      = is_wr & ~stall;
  assign commit_acc  = wr_acc & (region == RG_CTRL) & ctrl_commit;
  assign abort_acc   = wr_acc & (region == RG_CTRL) & abort_only;

  logic [31:0] status_w;

  always_comb begin
    status_w                       = '0;
    status_w[STAT_BUSY_BIT]        = (state_q != ST_IDLE);
    status_w[STAT_WAIT_BIT]        = (state_q == ST_WAIT_IDLE);
    status_w[STAT_VALID_BIT]       = cfg_valid_q;
    status_w[STAT_CNT_LSB +: 8]    = cnt_q;
  end

  always_comb begin
    reg_rdata_o = '0;
    if (reg_valid_i && !reg_write_i) begin
      case (region)
        RG_STATUS: reg_rdata_o = status_w;
        RG_CONST:  reg_rdata_o = sh_const_q[pe_idx];
        RG_CFG:    reg_rdata_o = sh_cfg_q[pe_idx][k_idx];
        default:   reg_rdata_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned p = 0; p < NPE; p++) begin
        sh_const_q[p] <= '0;
        for (int unsigned k = 0; k < NK; k++) sh_cfg_q[p][k] <= '0;
      end
    end else if (wr_acc) begin
      if (region == RG_CONST) begin
        sh_const_q[pe_idx] <= apply_wstrb(sh_const_q[pe_idx], reg_wdata_i, reg_wstrb_i);
      end else if (region == RG_CFG) begin
        sh_cfg_q[pe_idx][k_idx] <= apply_wstrb(sh_cfg_q[pe_idx][k_idx], reg_wdata_i, reg_wstrb_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      for (int unsigned p = 0; p < NPE; p++) begin
        act_const_q[p] <= '0;
        for (int unsigned k = 0; k < NK; k++) act_cfg_q[p][k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (commit_acc) state_q <= ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (abort_acc) begin
            state_q <= ST_IDLE;
          end else if (pea_idle_i) begin
            state_q <= ST_COPY;
            row_q   <= '0;
          end
        end
        ST_COPY: begin
          for (int unsigned p = 0; p < NPE; p++) begin
            if (p / M == 32'(row_q)) begin
              act_const_q[p] <= sh_const_q[p];
              for (int unsigned k = 0; k < NK; k++) act_cfg_q[p][k] <= sh_cfg_q[p][k];
            end
          end
          if (row_q == 3'(N - 1)) begin
            // Done-cycle outputs are registered on entry to DONE.
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            cfg_valid_q <= 1'b1;
            cnt_q       <= cnt_q + 8'd1;
          end else begin
            row_q <= row_q + 3'd1;
          end
        end
        ST_DONE: begin
          state_q <= commit_acc ? ST_WAIT_IDLE : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    active_constants_o = '0;
    active_cfg_o       = '0;
    for (int unsigned p = 0; p < NPE; p++) begin
      active_constants_o[p*32 +: 32] = act_const_q[p];
      for (int unsigned k = 0; k < NK; k++) begin
        active_cfg_o[(p*NK + k)*32 +: 32] = act_cfg_q[p][k];
      end
    end
  end

  assign cfg_valid_o   = cfg_valid_q;
  assign commit_done_o = done_q;

endmodule

// File: tb/tb_mage_cfg_shadow_regs.sv
module tb_mage_cfg_shadow_regs;

  localparam int N   = 4;
  localparam int M   = 4;
  localparam int NK  = 2;
  localparam int AW  = 12;
  localparam int CB  = 64;
  localparam int FB  = 128;
  localparam int NPE = N * M;

  logic                   clk_i = 1'b0;
  logic                   rst_n_i;
  logic                   reg_valid_i, reg_write_i;
  logic [AW-1:0]          reg_addr_i;
  logic [31:0]            reg_wdata_i;
  logic [3:0]             reg_wstrb_i;
  logic                   reg_ready_o, reg_error_o;
  logic [31:0]            reg_rdata_o;
  logic                   pea_idle_i;
  logic [NPE*32-1:0]      active_constants_o;
  logic [NPE*NK*32-1:0]   active_cfg_o;
  logic                   cfg_valid_o, commit_done_o;

  always #5 clk_i = ~clk_i;

  mage_cfg_shadow_regs #(
    .N             (N),
    .M             (M),
    .N_CFG_REGS_PE (NK),
    .AW            (AW),
    .CONST_BASE_W  (CB),
    .CFG_BASE_W    (FB)
  ) dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .reg_valid_i        (reg_valid_i),
    .reg_write_i        (reg_write_i),
    .reg_addr_i         (reg_addr_i),
    .reg_wdata_i        (reg_wdata_i),
    .reg_wstrb_i        (reg_wstrb_i),
    .reg_ready_o        (reg_ready_o),
    .reg_rdata_o        (reg_rdata_o),
    .reg_error_o        (reg_error_o),
    .pea_idle_i         (pea_idle_i),
    .active_constants_o (active_constants_o),
    .active_cfg_o       (active_cfg_o),
    .cfg_valid_o        (cfg_valid_o),
    .commit_done_o      (commit_done_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: shadow/active contents, commit count, valid flag.
  logic [31:0] m_sh_const [NPE];
  logic [31:0] m_sh_cfg   [NPE*NK];
  logic [31:0] m_act_const[NPE];
  logic [31:0] m_act_cfg  [NPE*NK];
  int          m_cnt;
  logic        m_valid;

  task automatic m_reset();
    for (int p = 0; p < NPE; p++) begin
      m_sh_const[p] = '0;
      m_act_const[p] = '0;
    end
    for (int i = 0; i < NPE*NK; i++) begin
      m_sh_cfg[i] = '0;
      m_act_cfg[i] = '0;
    end
    m_cnt = 0;
    m_valid = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_const(input int w); return w >= CB && w < CB + NPE; endfunction
  function automatic bit is_cfg(input int w);   return w >= FB && w < FB + NPE*NK; endfunction
  function automatic bit mapped(input int w);   return w == 0 || w == 1 || is_const(w) || is_cfg(w); endfunction

  // STATUS as seen while the commit engine is idle.
  function automatic logic [31:0] m_read(input int w);
    if (w == 1) return (32'(m_cnt) << 8) | (m_valid ? 32'h4 : 32'h0);
    if (is_const(w)) return m_sh_const[w - CB];
    if (is_cfg(w)) return m_sh_cfg[w - FB];
    return 32'h0;
  endfunction

  task automatic m_write(input int w, input logic [31:0] d, input logic [3:0] s);
    if (is_const(w)) m_sh_const[w - CB] = merge(m_sh_const[w - CB], d, s);
    else if (is_cfg(w)) m_sh_cfg[w - FB] = merge(m_sh_cfg[w - FB], d, s);
  endtask

  task automatic m_copy_row(input int r);
    for (int c = 0; c < M; c++) begin
      m_act_const[r*M + c] = m_sh_const[r*M + c];
      for (int k = 0; k < NK; k++) m_act_cfg[(r*M + c)*NK + k] = m_sh_cfg[(r*M + c)*NK + k];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_active(input string tag);
    for (int p = 0; p < NPE; p++)
      chk($sformatf("%s const[%0d]", tag, p), active_constants_o[p*32 +: 32], m_act_const[p]);
    for (int i = 0; i < NPE*NK; i++)
      chk($sformatf("%s cfg[%0d]", tag, i), active_cfg_o[i*32 +: 32], m_act_cfg[i]);
  endtask

  // Bus tasks start and end 1 time unit after a rising edge.
  task automatic drive(input bit wr, input int w, input logic [31:0] d, input logic [3:0] s);
    reg_valid_i = 1'b1;
    reg_write_i = wr;
    reg_addr_i  = AW'(w * 4 + int'($urandom_range(0, 3)));
    reg_wdata_i = d;
    reg_wstrb_i = s;
  endtask

  task automatic bus_wr(input int w, input logic [31:0] d, input logic [3:0] s, input string tag);
    drive(1'b1, w, d, s);
    @(negedge clk_i);
    chk({tag, " ready"}, 32'(reg_ready_o), 32'd1);
    chk({tag, " error"}, 32'(reg_error_o), 32'(!mapped(w)));
    @(posedge clk_i); #1;
    reg_valid_i = 1'b0;
    m_write(w, d, s);
  endtask

  task automatic bus_rd(input int w, input string tag);
    drive(1'b0, w, 32'h0, 4'h0);
    @(negedge clk_i);
    chk({tag, " ready"}, 32'(reg_ready_o), 32'd1);
    chk({tag, " error"}, 32'(reg_error_o), 32'(!mapped(w)));
    chk({tag, " rdata"}, reg_rdata_o, m_read(w));
    @(posedge clk_i); #1;
    reg_valid_i = 1'b0;
  endtask

  task automatic fill_random();
    for (int p = 0; p < NPE; p++)
      bus_wr(CB + p, $urandom, 4'($urandom_range(1, 15)), "fill const");
    for (int i = 0; i < NPE*NK; i++)
      bus_wr(FB + i, $urandom, 4'($urandom_range(1, 15)), "fill cfg");
  endtask

  // Commit and wait (bounded) for the done pulse; pea_idle_i must be 1.
  task automatic quick_commit(input logic [31:0] d, input string tag);
    bit seen;
    bus_wr(0, d, 4'h1, tag);
    seen = 0;
    for (int i = 0; i < 3*N + 10 && !seen; i++) begin
      @(negedge clk_i);
      if (commit_done_o) seen = 1;
      else begin @(posedge clk_i); #1; end
    end
    chk({tag, " done seen"}, 32'(seen), 32'd1);
    for (int r = 0; r < N; r++) m_copy_row(r);
    m_cnt = (m_cnt + 1) % 256;
    m_valid = 1'b1;
    if (seen) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    rst_n_i = 1'b0;
    reg_valid_i = 1'b0; reg_write_i = 1'b0; reg_addr_i = '0;
    reg_wdata_i = '0; reg_wstrb_i = '0; pea_idle_i = 1'b0;
    m_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Reset state
    chk("rst cfg_valid", 32'(cfg_valid_o), 32'd0);
    chk("rst done", 32'(commit_done_o), 32'd0);
    chk_active("rst");
    bus_rd(1, "rst status");
    bus_rd(CB, "rst const0");

    // Byte strobes
    bus_wr(CB + 5, 32'hDEADBEEF, 4'b0011, "strb wr");
    bus_rd(CB + 5, "strb rd");
    chk("strb active pe5", active_constants_o[5*32 +: 32], 32'h0);

    // Fill and commit with cycle-exact row timing
    fill_random();
    for (int i = 0; i < 6; i++) begin
      int w;
      w = ($urandom_range(0, 1) == 0) ? CB + int'($urandom_range(0, NPE-1))
                                      : FB + int'($urandom_range(0, NPE*NK-1));
      bus_rd(w, "fill rd");
    end
    pea_idle_i = 1'b1;
    bus_wr(0, 32'h1, 4'h1, "commit");
    @(negedge clk_i);
    chk("t+1 done", 32'(commit_done_o), 32'd0);
    chk_active("t+1");
    @(posedge clk_i); #1;
    for (int r = 0; r < N; r++) begin
      @(negedge clk_i);
      chk($sformatf("copy r%0d done", r), 32'(commit_done_o), 32'd0);
      chk_active($sformatf("copy r%0d", r));
      @(posedge clk_i); #1;
      m_copy_row(r);
    end
    m_cnt = 1; m_valid = 1'b1;
    @(negedge clk_i);
    chk("done pulse", 32'(commit_done_o), 32'd1);
    chk("done cfg_valid", 32'(cfg_valid_o), 32'd1);
    chk_active("done");
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("after done", 32'(commit_done_o), 32'd0);
    @(posedge clk_i); #1;
    bus_rd(1, "status cnt1");

    // Stall while waiting for idle, then abort
    pea_idle_i = 1'b0;
    bus_wr(0, 32'h1, 4'h1, "commit2");
    drive(1'b1, CB + 2, 32'hA5A5_5A5A, 4'hF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("stall ready", 32'(reg_ready_o), 32'd0);
      chk("stall done", 32'(commit_done_o), 32'd0);
      @(posedge clk_i); #1;
    end
    drive(1'b1, 0, 32'h2, 4'h1);
    @(negedge clk_i);
    chk("abort ready", 32'(reg_ready_o), 32'd1);
    @(posedge clk_i); #1;
    reg_valid_i = 1'b0;
    @(negedge clk_i);
    chk("abort no done", 32'(commit_done_o), 32'd0);
    @(posedge clk_i); #1;
    bus_rd(1, "abort status");
    chk_active("abort");
    bus_wr(CB + 2, 32'hA5A5_5A5A, 4'hF, "post-abort wr");
    bus_rd(CB + 2, "post-abort rd");

    // Abort wins over pea_idle_i in the same cycle
    bus_wr(0, 32'h1, 4'h1, "commit3");
    pea_idle_i = 1'b1;
    bus_wr(0, 32'h2, 4'h1, "abort prio");
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk_i);
      chk("prio no done", 32'(commit_done_o), 32'd0);
      @(posedge clk_i); #1;
    end
    bus_rd(1, "prio status");
    chk_active("prio");

    // commit|abort together in IDLE acts as commit
    quick_commit(32'h3, "commit+abort");
    chk_active("commit+abort");
    bus_rd(1, "status cnt2");

    // Unmapped and STATUS write
    bus_rd(3, "unmapped rd3");
    bus_rd(2, "unmapped rd2");
    bus_wr(FB + NPE*NK, 32'hFFFF_FFFF, 4'hF, "unmapped wr");
    bus_rd(FB + NPE*NK - 1, "last cfg rd");
    bus_rd(CB + NPE - 1, "last const rd");
    bus_wr(1, 32'hFFFF_FFFF, 4'hF, "status wr");
    bus_rd(1, "status after wr");

    // Asynchronous reset in the middle of COPY
    fill_random();
    bus_wr(0, 32'h1, 4'h1, "commit rst");
    repeat (3) begin @(posedge clk_i); #1; end
    #2 rst_n_i = 1'b0;
    #1;
    m_reset();
    chk("midcopy cfg_valid", 32'(cfg_valid_o), 32'd0);
    chk("midcopy done", 32'(commit_done_o), 32'd0);
    chk_active("midcopy");
    @(negedge clk_i) rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    bus_rd(1, "post-rst status");
    bus_rd(CB + 1, "post-rst const");

    // Commit counter wraps 255 -> 0
    fill_random();
    for (int i = 0; i < 255; i++) quick_commit(32'h1, "wrap");
    chk_active("wrap");
    bus_rd(1, "status cnt255");
    quick_commit(32'h1, "wrap last");
    bus_rd(1, "status cnt0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
